// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet TX FIFO arbiter: FSM state encoding
// and the byte-length to word-count helper.
package eth_tx_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_XFER      = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // ceil(len / bpw); bpw is an elaboration-time constant at every call site
  function automatic logic [31:0] words_for_len(input logic [31:0] len,
                                                input logic [31:0] bpw);
    return (len + bpw - 32'd1) / bpw;
  endfunction

endpackage

// File: rtl/eth_tx_fifo_arb_rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot combinational grant.
// The fairness pointer only moves when the owner releases the path.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       rel_i,
  input  logic       rel_ch_i,
  output logic [1:0] gnt_o
);

  // last_q = 1 means ch1 was granted last, so ch0 wins the next tie
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_q)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (rel_i) begin
      last_q <= rel_ch_i;
    end
  end

endmodule

// File: rtl/eth_tx_fifo_arb.sv
// Arbitrates two prefetch FIFOs onto a single UDP transmit core, one whole
// frame at a time, with underflow and done-timeout error tracking.
module eth_tx_fifo_arb
  import eth_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch0_req,
  input  logic [LEN_W-1:0]  ch0_len,
  output logic              ch0_ack,
  input  logic [DATA_W-1:0] ch0_rd_data,
  input  logic              ch0_rd_vld,
  output logic              ch0_rd_en,
  input  logic              ch1_req,
  input  logic [LEN_W-1:0]  ch1_len,
  output logic              ch1_ack,
  input  logic [DATA_W-1:0] ch1_rd_data,
  input  logic              ch1_rd_vld,
  output logic              ch1_rd_en,
  output logic              tx_start,
  output logic [LEN_W-1:0]  tx_byte_num,
  input  logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic [1:0]        gnt,
  output logic              err_underflow,
  output logic              err_timeout
);

  localparam int BPW = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [LEN_W-1:0]  byte_num_q, byte_num_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              tx_start_q, tx_start_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_uf_q, err_uf_d;
  logic              err_to_q, err_to_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic [1:0]        arb_gnt;
  logic              finish;
  logic [LEN_W-1:0]  sel_len;
  logic              head_vld;
  logic [DATA_W-1:0] head_data;
  logic              xfer_pop;
  logic              to_expired;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({ch1_req, ch0_req}),
    .rel_i    (finish),
    .rel_ch_i (gnt_q[1]),
    .gnt_o    (arb_gnt)
  );

  assign sel_len    = arb_gnt[1] ? ch1_len : ch0_len;
  assign head_vld   = (gnt_q[0] & ch0_rd_vld) | (gnt_q[1] & ch1_rd_vld);
  assign head_data  = gnt_q[1] ? ch1_rd_data : ch0_rd_data;
  assign xfer_pop   = (state_q == ST_XFER) && tx_req && (words_q != '0);
  assign to_expired = (state_q != ST_IDLE) && (to_q == '1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    byte_num_d = byte_num_q;
    words_d    = words_q;
    tx_start_d = 1'b0;
    ack_d      = 2'b00;
    err_uf_d   = err_uf_q;
    err_to_d   = err_to_q;
    finish     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_d      = arb_gnt;
          byte_num_d = sel_len;
          words_d    = LEN_W'(words_for_len(32'(sel_len), 32'(BPW)));
          tx_start_d = (sel_len != '0);
          state_d    = ST_START;
        end
      end
      ST_START: begin
        // Zero-length frames never reach the UDP core
        if (words_q == '0) finish = 1'b1;
        else               state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tx_done) begin
          finish = 1'b1;
        end else if (xfer_pop) begin
          words_d = words_q - LEN_W'(1);
          if (words_q == LEN_W'(1)) state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        if (tx_done) finish = 1'b1;
      end
    endcase

    if (xfer_pop && !head_vld) err_uf_d = 1'b1;

    if (to_expired) begin
      finish   = 1'b1;
      err_to_d = 1'b1;
    end

    if (finish) begin
      ack_d   = gnt_q;
      gnt_d   = 2'b00;
      state_d = ST_IDLE;
    end

    // Timeout only measures silence from the UDP core within one state
    if (state_q == ST_IDLE || state_d != state_q || tx_req) to_d = '0;
    else                                                    to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      byte_num_q <= '0;
      words_q    <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= 2'b00;
      err_uf_q   <= 1'b0;
      err_to_q   <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      byte_num_q <= byte_num_d;
      words_q    <= words_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      err_uf_q   <= err_uf_d;
      err_to_q   <= err_to_d;
      to_q       <= to_d;
    end
  end

  assign ch0_rd_en     = xfer_pop & gnt_q[0];
  assign ch1_rd_en     = xfer_pop & gnt_q[1];
  assign tx_data       = ((state_q == ST_XFER) && head_vld) ? head_data : '0;
  assign tx_start      = tx_start_q;
  assign tx_byte_num   = byte_num_q;
  assign gnt           = gnt_q;
  assign ch0_ack       = ack_q[0];
  assign ch1_ack       = ack_q[1];
  assign err_underflow = err_uf_q;
  assign err_timeout   = err_to_q;

endmodule

// File: doc/eth_tx_fifo_arb.md
ETH_TX_FIFO_ARB -- requirements
Module: eth_tx_fifo_arb

Interface
REQ-001 Parameter DATA_W, default 32: FIFO word width and tx_data width in bits.
REQ-002 Parameter LEN_W, default 16: frame byte-length width.
REQ-003 Parameter TO_W, default 16: width of the done-timeout counter; the timeout is 2^TO_W-1 cycles.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 chN_req  input  1  per channel N=0,1: level, frame ready in FIFO N.
REQ-007 chN_len  input  LEN_W  per channel: frame byte count, stable while chN_req is high.
REQ-008 chN_ack  output  1  per channel: one-cycle pulse when the frame is finished or aborted.
REQ-009 chN_rd_data  input  DATA_W  per channel: prefetch FIFO head word.
REQ-010 chN_rd_vld  input  1  per channel: FIFO head valid.
REQ-011 chN_rd_en  output  1  per channel: pop the FIFO head.
REQ-012 tx_start  output  1  one-cycle pulse that starts a UDP frame.
REQ-013 tx_byte_num  output  LEN_W  registered byte count of the granted frame.
REQ-014 tx_req  input  1  UDP core requests one word per high cycle.
REQ-015 tx_data  output  DATA_W  word for the current tx_req cycle.
REQ-016 tx_done  input  1  UDP core frame complete.
REQ-017 gnt  output  2  one-hot owner of the TX path; 00 when idle.
REQ-018 err_underflow  output  1  sticky error flag.
REQ-019 err_timeout  output  1  sticky error flag.

Function
REQ-020 The FSM SHALL have states IDLE, START, XFER, WAIT_DONE.
REQ-021 IDLE: when any chN_req is high, select by round-robin, with priority to the channel that was not last granted; after reset ch0 has priority.
REQ-022 Both requests high in the same cycle: grant the non-last channel; ch0 after reset.
REQ-023 On grant: latch chN_len into tx_byte_num, load words_left = ceil(len/(DATA_W/8)), set gnt, go to START.
REQ-024 Grant with len=0: skip to the ack path; no tx_start, no pops, chN_ack pulses one cycle later, return to IDLE.
REQ-025 START: assert tx_start for exactly one cycle, then go to XFER.
REQ-026 XFER: chN_rd_en = tx_req & gnt[N] & (words_left != 0), combinational; tx_data = granted chN_rd_data, or 0 when the FIFO is not valid.
REQ-027 Each tx_req cycle in XFER decrements words_left by 1 (saturating at 0); at 0, go to WAIT_DONE.
REQ-028 tx_req in XFER while granted chN_rd_vld=0: set err_underflow, drive tx_data=0, still decrement words_left.
REQ-029 tx_req while words_left=0 or outside XFER: ignored; no pop.
REQ-030 WAIT_DONE: tx_done causes chN_ack to pulse on the next cycle, gnt to clear, the last-granted pointer to update, and the FSM to return to IDLE.
REQ-031 tx_done seen in XFER: treated as early completion; same as REQ-030, and remaining words are not popped.
REQ-032 A timeout counter runs in START/XFER/WAIT_DONE and clears on every tx_req or state change; on expiry set err_timeout, pulse ack, and return to IDLE.
REQ-033 Requests arriving while busy wait; there is no pre-emption.
REQ-034 Error flags clear only on reset.

Reset
REQ-035 rst_n low SHALL force, asynchronously: state IDLE, gnt=00, tx_start=0, tx_byte_num=0, chN_ack=0, words_left=0, last-granted pointer=ch1 (so ch0 wins first), error flags 0, timeout counter 0.
REQ-036 Reset mid-frame SHALL abandon the frame with no ack; FIFO contents are the owner's responsibility.
REQ-037 Release SHALL be synchronous to clk; the owner supplies a synchronised rst_n.

Structure
REQ-038 FSM state encoding and the word-count function ceil(len/bytes-per-word) SHALL live in shared package eth_tx_pkg.
REQ-039 Round-robin selection SHALL be one sub-module, rr_arb2 (2 requesters, one-hot grant, pointer update on a release strobe).
REQ-040 Implementation SHALL be synchronous, single clock, no latches, estimated at 150-300 lines.

Verification
REQ-041 ch0_req=1, len=8, tx_req high 2 cycles, tx_done -> tx_start 1 pulse, tx_byte_num=8, 2 ch0 pops, ch0_ack 1 cycle after tx_done.
REQ-042 ch0 and ch1 requesting simultaneously from reset, len=4 each -> ch0 frame, then ch1 frame; gnt sequence 01,00,10.
REQ-043 ch1_req, len=5 -> 2 words popped (ceil), tx_byte_num=5.
REQ-044 len=0 on ch0 -> no tx_start, ch0_ack pulses, gnt returns to 00.
REQ-045 tx_req with ch0_rd_vld=0 -> err_underflow=1, tx_data=0; tx_done withheld 2^TO_W cycles -> err_timeout=1 and ack pulses.
REQ-046 rst_n low in XFER -> all outputs at reset values immediately; no ack; next request granted to ch0.
